// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// data-memory freezes, plus stall/flush counters and a sticky mem-timeout flag.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             ex_MemRead_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_busy_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_en_o,
  output logic             idex_flush_o,
  output logic             exmem_en_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             timeout_o
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          load_use;
  logic          branch_flush;

  assign load_use = ex_MemRead_i && (ex_rd_i != 5'd0) &&
                    ((id_use_rs1_i && (ex_rd_i == id_rs1_i)) ||
                     (id_use_rs2_i && (ex_rd_i == id_rs2_i)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // wait_cnt holds the number of consecutive busy cycles seen so far
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      RUN: begin
        if (mem_busy_i) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WW'(1);
        end else begin
          wait_nxt  = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_busy_i) begin
          if (wait_cnt != TMO) wait_nxt = wait_cnt + 1'b1;
        end else begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  // Leaving MEM_WAIT applies the RUN rules in the same cycle, so the
  // controls depend only on the inputs; freeze outranks branch outranks load-use.
  always_comb begin
    pc_en_o      = 1'b1;
    ifid_en_o    = 1'b1;
    ifid_flush_o = 1'b0;
    idex_en_o    = 1'b1;
    idex_flush_o = 1'b0;
    exmem_en_o   = 1'b1;
    branch_flush = 1'b0;
    if (mem_busy_i) begin
      pc_en_o    = 1'b0;
      ifid_en_o  = 1'b0;
      idex_en_o  = 1'b0;
      exmem_en_o = 1'b0;
    end else if (ex_branch_taken_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      branch_flush = 1'b1;
    end else if (load_use) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_flush_o = 1'b1;
    end
    if (rst_i) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_en_o    = 1'b0;
      exmem_en_o   = 1'b0;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      branch_flush = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      timeout_o   <= 1'b0;
    end else begin
      if (!pc_en_o)     stall_cnt_o <= stall_cnt_o + 1'b1;
      if (branch_flush) flush_cnt_o <= flush_cnt_o + 1'b1;
      if (mem_busy_i && (wait_nxt == TMO)) timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle
// sequences and bursty random stimulus against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int TMO   = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1, rs2, rd;
  logic             u1, u2, mr, br, busy;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             timeout;
  logic [5:0]       ctl;

  int n_chk = 0;
  int n_err = 0;
  int m_stall, m_flush, m_run;
  bit m_to;

  always #5 clk = ~clk;

  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en};

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(u1), .id_use_rs2_i(u2),
    .ex_MemRead_i(mr), .ex_rd_i(rd), .ex_branch_taken_i(br), .mem_busy_i(busy),
    .pc_en_o(pc_en), .ifid_en_o(ifid_en), .ifid_flush_o(ifid_flush),
    .idex_en_o(idex_en), .idex_flush_o(idex_flush), .exmem_en_o(exmem_en),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .timeout_o(timeout)
  );

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, br, busy;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(input logic [4:0] a, b, d, input logic p, q, m, r, y,
                              input logic [5:0] e);
    vec_t v;
    v.rs1 = a; v.rs2 = b; v.rd = d; v.u1 = p; v.u2 = q;
    v.mr = m; v.br = r; v.busy = y; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected controls are {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}.
  task automatic step(input bit use_tbl, input logic [5:0] tbl_exp);
    logic       lu;
    logic [5:0] e;
    #1;
    lu = mr && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    if (rst)       e = 6'b001010;
    else if (busy) e = 6'b000000;
    else if (br)   e = 6'b111111;
    else if (lu)   e = 6'b000111;
    else           e = 6'b110101;
    chk("ctl", 32'(ctl), 32'(e));
    if (use_tbl) chk("vec", 32'(ctl), 32'(tbl_exp));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    chk("timeout", 32'(timeout), 32'(m_to));
    @(posedge clk);
    if (rst) begin
      m_stall = 0; m_flush = 0; m_run = 0; m_to = 0;
    end else begin
      if (!e[5]) m_stall = (m_stall + 1) % (1 << CNT_W);
      if (br && !busy) m_flush = (m_flush + 1) % (1 << CNT_W);
      if (busy) begin
        m_run = (m_run < TMO) ? m_run + 1 : TMO;
        if (m_run >= TMO) m_to = 1;
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic drive(input vec_t v);
    rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; u1 = v.u1; u2 = v.u2;
    mr = v.mr; br = v.br; busy = v.busy;
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; mr = 0; br = 0; busy = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle();
    step(0, '0);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = mk(5, 0, 5, 1, 0, 1, 0, 0, 6'b000111); // load-use on rs1
    tbl[1] = mk(5, 0, 0, 1, 0, 1, 0, 0, 6'b110101); // rd = x0
    tbl[2] = mk(5, 0, 5, 0, 0, 1, 0, 0, 6'b110101); // rs1 not read
    tbl[3] = mk(1, 7, 7, 1, 1, 1, 0, 0, 6'b000111); // load-use on rs2
    tbl[4] = mk(5, 0, 5, 1, 0, 0, 0, 0, 6'b110101); // not a load
    tbl[5] = mk(5, 0, 5, 1, 0, 1, 1, 0, 6'b111111); // branch beats load-use
    tbl[6] = mk(2, 3, 9, 1, 1, 0, 1, 0, 6'b111111); // branch alone
    tbl[7] = mk(1, 4, 4, 1, 0, 1, 0, 0, 6'b110101); // rs2 match but unused
    tbl[8] = mk(4, 4, 4, 1, 1, 1, 1, 1, 6'b000000); // freeze beats branch
    tbl[9] = mk(3, 3, 6, 1, 1, 1, 0, 0, 6'b110101); // no hazard

    rst = 1'b1; idle();
    m_stall = 0; m_flush = 0; m_run = 0; m_to = 0;
    @(posedge clk); #1;
    step(0, '0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      step(1, tbl[i].exp);
    end

    // single load-use bubble counts one stall
    do_reset();
    drive(tbl[0]); step(0, '0);
    idle(); step(0, '0);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // branch held through a 10-cycle freeze flushes once afterwards
    do_reset();
    busy = 1; br = 1;
    for (int i = 0; i < 10; i++) step(0, '0);
    chk("freeze_stall_cnt", 32'(stall_cnt), 32'd10);
    chk("freeze_flush_cnt", 32'(flush_cnt), 32'd0);
    busy = 0; step(0, '0);
    chk("post_freeze_flush", 32'(flush_cnt), 32'd1);
    br = 0;

    // timeout after exactly MEM_TIMEOUT busy cycles, sticky until reset
    do_reset();
    busy = 1;
    for (int i = 0; i < TMO - 1; i++) step(0, '0);
    chk("timeout_early", 32'(timeout), 32'd0);
    step(0, '0);
    chk("timeout_set", 32'(timeout), 32'd1);
    busy = 0; step(0, '0); step(0, '0);
    chk("timeout_sticky", 32'(timeout), 32'd1);
    do_reset();
    chk("timeout_clr", 32'(timeout), 32'd0);

    // reset mid-wait restarts the busy count
    busy = 1;
    for (int i = 0; i < 5; i++) step(0, '0);
    rst = 1; step(0, '0);
    rst = 0;
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < TMO - 1; i++) step(0, '0);
    chk("rst_wait_restart", 32'(timeout), 32'd0);
    busy = 0; step(0, '0);

    // bursty random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rs1  = 5'($urandom_range(0, 3));
      rs2  = 5'($urandom_range(0, 3));
      rd   = 5'($urandom_range(0, 3));
      u1   = 1'($urandom_range(0, 1));
      u2   = 1'($urandom_range(0, 1));
      mr   = 1'($urandom_range(0, 1));
      br   = ($urandom_range(0, 5) == 0);
      busy = busy ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
      rst  = ($urandom_range(0, 299) == 0);
      step(0, '0);
    end
    rst = 0; idle(); step(0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
